// File: rtl/timerio_pkg.sv
// timerio shared definitions: register map
// and CTRL/STATUS bit positions.
package timerio_pkg;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_PRESC,
    REG_RELOAD_H,
    REG_RELOAD_L,
    REG_COUNT_H,
    REG_COUNT_L,
    REG_RSVD
  } reg_t;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_PER = 1;
  localparam int CTRL_IE  = 2;
  localparam int CTRL_W   = 3;

  localparam int STAT_OVF = 0;
  localparam int STAT_RUN = 1;

endpackage

// File: rtl/timerio_if.sv
// timerio CPU bus: 3-bit offset, 8-bit data,
// rw=1 read, cs = decode AND vma.
interface timerio_if;
  logic [2:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;

  modport master (
    output AD, DI, rw, cs,
    input  DO
  );

  modport slave (
    input  AD, DI, rw, cs,
    output DO
  );
endinterface

// File: rtl/timerio_presc.sv
// timerio prescaler: one tick every
// divisor+1 enabled clocks.
module timerio_presc (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clear,
  input  logic [7:0] divisor,
  output logic       tick
);
  logic [7:0] cnt;

  assign tick = en & (cnt == divisor);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? 8'd0 : cnt + 8'd1;
    end
  end
endmodule

// File: rtl/timerio.sv
// timerio: 16-bit down-counter with prescaler,
// one-shot/periodic modes and level irq.
module timerio
  import timerio_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  timerio_if.slave  bus,
  output logic      irq
);
  logic [CTRL_W-1:0] ctrl;
  logic              ovf;
  logic [7:0]        presc;
  logic [7:0]        stage;
  logic [7:0]        shadow;
  logic [15:0]       reload;
  logic [15:0]       count;
  logic [7:0]        status;

  logic wr, rd, ctrl_wr, en_rise;
  logic presc_en, presc_clr;
  logic tick, expire;

  assign wr      = bus.cs & ~bus.rw;
  assign rd      = bus.cs & bus.rw;
  assign ctrl_wr = wr & (reg_t'(bus.AD) == REG_CTRL);
  assign en_rise = ctrl_wr & bus.DI[CTRL_EN]
                 & ~ctrl[CTRL_EN];

  // Any CTRL write freezes the prescaler for
  // that edge, so a racing tick is dropped.
  assign presc_en  = ctrl[CTRL_EN] & ~ctrl_wr;
  assign presc_clr = en_rise
                   | (wr & (reg_t'(bus.AD) == REG_PRESC));

  timerio_presc u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (presc_en),
    .clear   (presc_clr),
    .divisor (presc),
    .tick    (tick)
  );

  assign expire = tick & (count == 16'd1);
  assign irq    = ovf & ctrl[CTRL_IE];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl   <= '0;
      ovf    <= 1'b0;
      presc  <= '0;
      stage  <= '0;
      reload <= '0;
      count  <= '0;
      shadow <= '0;
    end else begin
      if (tick) begin
        if (expire) begin
          ovf <= 1'b1;
          if (ctrl[CTRL_PER]) begin
            count <= reload;
          end else begin
            count         <= '0;
            ctrl[CTRL_EN] <= 1'b0;
          end
        end else begin
          count <= count - 16'd1;
        end
      end
      if (rd && reg_t'(bus.AD) == REG_COUNT_H) begin
        shadow <= count[7:0];
      end
      if (wr) begin
        unique case (reg_t'(bus.AD))
          REG_CTRL: begin
            ctrl <= bus.DI[CTRL_W-1:0];
            if (en_rise) count <= reload;
          end
          REG_STATUS: begin
            // hardware set wins over a clear
            if (bus.DI[STAT_OVF] && !expire)
              ovf <= 1'b0;
          end
          REG_PRESC:    presc <= bus.DI;
          REG_RELOAD_H: stage <= bus.DI;
          REG_RELOAD_L: begin
            reload <= {stage, bus.DI};
            if (!ctrl[CTRL_EN])
              count <= {stage, bus.DI};
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status           = '0;
    status[STAT_OVF] = ovf;
    status[STAT_RUN] = ctrl[CTRL_EN];
  end

  always_comb begin
    bus.DO = 8'h00;
    if (rd) begin
      unique case (reg_t'(bus.AD))
        REG_CTRL:     bus.DO = {5'd0, ctrl};
        REG_STATUS:   bus.DO = status;
        REG_PRESC:    bus.DO = presc;
        REG_RELOAD_H: bus.DO = reload[15:8];
        REG_RELOAD_L: bus.DO = reload[7:0];
        REG_COUNT_H:  bus.DO = count[15:8];
        REG_COUNT_L:  bus.DO = shadow;
        default:      bus.DO = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_timerio.sv
// timerio bench: register table, timing
// sequences and random ops vs. a tick model.
module tb_timerio;
  import timerio_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;

  timerio_if bus ();

  timerio dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: ticks remaining to expiry and
  // enabled clocks remaining to next tick
  bit         m_en, m_per, m_ie, m_ovf;
  logic [7:0] m_presc, m_stage, m_shadow;
  logic [15:0] m_reload;
  int         m_left, m_wait;

  logic [7:0] d, v;

  typedef struct {
    bit         wr;
    logic [2:0] ad;
    logic [7:0] di;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string n,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h",
               n, act, exp);
    end
  endtask

  task automatic check_bit(input string n,
                           input logic act,
                           input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b",
               n, act, exp);
    end
  endtask

  function automatic int span(input logic [15:0] r);
    return (r == 16'd0) ? 65536 : int'(r);
  endfunction

  function automatic logic [7:0] mread(input logic [2:0] a);
    case (a)
      3'd0: return {5'd0, m_ie, m_per, m_en};
      3'd1: return {6'd0, m_en, m_ovf};
      3'd2: return m_presc;
      3'd3: return m_reload[15:8];
      3'd4: return m_reload[7:0];
      3'd5: return m_left[15:8];
      3'd6: return m_shadow;
      default: return 8'h00;
    endcase
  endfunction

  task automatic mreset();
    m_en = 0; m_per = 0; m_ie = 0; m_ovf = 0;
    m_presc = '0; m_stage = '0; m_shadow = '0;
    m_reload = '0; m_left = 0; m_wait = 0;
  endtask

  task automatic mstep(input logic c, input logic r,
                       input logic [2:0] a,
                       input logic [7:0] dd);
    bit w, cw, en0, tk, ex;
    w = c && !r;
    cw = w && (a == 3'd0);
    en0 = m_en;
    tk = 0;
    ex = 0;
    if (c && r && a == 3'd5) m_shadow = m_left[7:0];
    if (m_en && !cw) begin
      if (m_wait == 0) begin
        tk = 1;
        m_wait = int'(m_presc);
      end else begin
        m_wait--;
      end
    end
    if (tk) begin
      if (m_left == 1) begin
        ex = 1;
        m_ovf = 1;
        if (m_per) m_left = span(m_reload);
        else begin
          m_left = 0;
          m_en = 0;
        end
      end else begin
        m_left--;
      end
    end
    if (w) begin
      case (a)
        3'd0: begin
          if (dd[0] && !en0) begin
            m_left = span(m_reload);
            m_wait = int'(m_presc);
          end
          m_en = dd[0]; m_per = dd[1]; m_ie = dd[2];
        end
        3'd1: if (dd[0] && !ex) m_ovf = 0;
        3'd2: begin
          m_presc = dd;
          m_wait = int'(dd);
        end
        3'd3: m_stage = dd;
        3'd4: begin
          m_reload = {m_stage, dd};
          if (!en0) m_left = span(m_reload);
        end
        default: ;
      endcase
    end
  endtask

  // one bus cycle, entered and left at negedge
  task automatic cyc(input logic c, input logic r,
                     input logic [2:0] a,
                     input logic [7:0] dd,
                     output logic [7:0] rv);
    bus.cs = c; bus.rw = r; bus.AD = a; bus.DI = dd;
    #1;
    rv = bus.DO;
    if (c && r) check("rd_model", rv, mread(a));
    else check("do_idle", rv, 8'h00);
    mstep(c, r, a, dd);
    @(negedge clk);
    bus.cs = 1'b0;
    bus.rw = 1'b1;
    check_bit("irq_model", irq, m_ovf & m_ie);
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [7:0] dd);
    logic [7:0] t;
    cyc(1'b1, 1'b0, a, dd, t);
  endtask

  task automatic rdv(input logic [2:0] a,
                     output logic [7:0] rv);
    cyc(1'b1, 1'b1, a, 8'h00, rv);
  endtask

  task automatic rdchk(input string n,
                       input logic [2:0] a,
                       input logic [7:0] exp);
    logic [7:0] t;
    rdv(a, t);
    check(n, t, exp);
  endtask

  task automatic idle(input int n);
    logic [7:0] t;
    repeat (n) cyc(1'b0, 1'b1, 3'd0, 8'h00, t);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.cs = 1'b0;
    mreset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic setup(input logic [7:0] p,
                       input logic [15:0] rl,
                       input logic [7:0] c);
    do_reset();
    wr(REG_PRESC, p);
    wr(REG_RELOAD_H, rl[15:8]);
    wr(REG_RELOAD_L, rl[7:0]);
    wr(REG_CTRL, c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cs = 1'b0; bus.rw = 1'b1;
    bus.AD = '0;   bus.DI = '0;
    mreset();
    tbl = '{
      '{1, REG_PRESC,    8'hA5, 8'h00},
      '{0, REG_PRESC,    8'h00, 8'hA5},
      '{1, REG_RELOAD_H, 8'h12, 8'h00},
      '{0, REG_RELOAD_H, 8'h00, 8'h00},
      '{1, REG_RELOAD_L, 8'h34, 8'h00},
      '{0, REG_RELOAD_H, 8'h00, 8'h12},
      '{0, REG_RELOAD_L, 8'h00, 8'h34},
      '{0, REG_COUNT_H,  8'h00, 8'h12},
      '{0, REG_COUNT_L,  8'h00, 8'h34},
      '{1, REG_RSVD,     8'hFF, 8'h00},
      '{0, REG_RSVD,     8'h00, 8'h00},
      '{1, REG_CTRL,     8'hFE, 8'h00},
      '{0, REG_CTRL,     8'h00, 8'h06},
      '{0, REG_STATUS,   8'h00, 8'h00}
    };

    // reset state, DO during reset
    @(negedge clk);
    check_bit("rst_irq", irq, 1'b0);
    bus.cs = 1'b1; bus.AD = REG_PRESC;
    #1;
    check("rst_do", bus.DO, 8'h00);
    bus.cs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 8; a++)
      rdchk("rst_reg", 3'(a), 8'h00);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) wr(tbl[i].ad, tbl[i].di);
      else rdchk("tbl", tbl[i].ad, tbl[i].exp);
    end

    // periodic, 5-clock period
    setup(8'd0, 16'h0005, 8'h07);
    idle(4);
    check_bit("per_early", irq, 1'b0);
    idle(1);
    check_bit("per_rise", irq, 1'b1);
    rdchk("per_stat", REG_STATUS, 8'h03);
    wr(REG_STATUS, 8'h01);
    check_bit("per_clr", irq, 1'b0);
    idle(2);
    check_bit("per_early2", irq, 1'b0);
    idle(1);
    check_bit("per_rise2", irq, 1'b1);

    // one-shot, presc 3, reload 2
    setup(8'd3, 16'h0002, 8'h05);
    idle(7);
    rdchk("os_run", REG_STATUS, 8'h02);
    rdchk("os_done", REG_STATUS, 8'h01);
    rdchk("os_ctrl", REG_CTRL, 8'h04);
    rdchk("os_cnth", REG_COUNT_H, 8'h00);
    rdchk("os_cntl", REG_COUNT_L, 8'h00);
    wr(REG_STATUS, 8'h01);
    idle(40);
    rdchk("os_quiet", REG_STATUS, 8'h00);

    // clear racing an expiry
    setup(8'd0, 16'h0003, 8'h07);
    idle(2);
    wr(REG_STATUS, 8'h01);
    check_bit("race_irq", irq, 1'b1);
    rdchk("race_stat", REG_STATUS, 8'h03);
    wr(REG_STATUS, 8'h01);
    check_bit("race_clr", irq, 1'b0);

    // COUNT_L shadow
    setup(8'd0, 16'h1234, 8'h01);
    idle(4);
    rdchk("sh_hi", REG_COUNT_H, 8'h12);
    idle(10);
    rdchk("sh_lo", REG_COUNT_L, 8'h30);

    // reset mid-count
    setup(8'd0, 16'h0003, 8'h07);
    idle(5);
    check_bit("mid_irq", irq, 1'b1);
    rst = 1'b0;
    mreset();
    #1;
    check_bit("mid_rst_irq", irq, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 8; a++)
      rdchk("mid_reg", 3'(a), 8'h00);
    idle(100);
    rdchk("mid_quiet", REG_STATUS, 8'h00);

    // random ops against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0, 1: rdv(3'($urandom_range(0, 7)), v);
        2: begin
          d = 8'($urandom);
          d[0] = ($urandom_range(0, 3) != 0);
          wr(REG_CTRL, d);
        end
        3: wr(REG_STATUS, 8'($urandom_range(0, 1)));
        4: wr(REG_PRESC, 8'($urandom_range(0, 3)));
        5: wr(REG_RELOAD_H,
              8'($urandom_range(0, 7) == 0));
        6: wr(REG_RELOAD_L,
              8'($urandom_range(0, 12)));
        default: idle($urandom_range(1, 8));
      endcase
    end

    // reload 0 means 65536 ticks
    setup(8'd0, 16'h0000, 8'h07);
    idle(1);
    rdchk("wrap_hi", REG_COUNT_H, 8'hFF);
    rdchk("wrap_lo", REG_COUNT_L, 8'hFF);
    idle(65532);
    check_bit("wrap_early", irq, 1'b0);
    idle(1);
    check_bit("wrap_rise", irq, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
